// File: rtl/irrigation_pkg.sv
// Shared types and constants for the irrigation sequencer and its BCD timer.
package irrigation_pkg;

  // Top-level controller states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IRRIGATE = 2'd1,
    FAULT    = 2'd2
  } state_t;

  // Watering mode, latched at the start of each run.
  typedef enum logic {
    DRIP     = 1'b0,
    SPRINKLE = 1'b1
  } mode_t;

  // BCD digit for minutes / seconds units, and the 0..5 seconds-tens digit.
  typedef logic [3:0] bcd_digit_t;
  typedef logic [2:0] sec_tens_t;

  localparam sec_tens_t  MAX_SEC_TENS = 3'd5;
  localparam bcd_digit_t MAX_BCD      = 4'd9;

  // A gauge is valid when it is a thermometer code: no sensor submerged
  // while the one below it is dry. Narrow gauges are zero-extended to 8 bits.
  function automatic logic gauge_is_thermometer(input logic [7:0] g);
    logic ok;
    ok = 1'b1;
    for (int i = 1; i < 8; i++) begin
      if (g[i] && !g[i-1]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_countdown.sv
// M:SS BCD countdown timer. Clear beats load beats tick; it stops at 0:00.
module bcd_countdown
  import irrigation_pkg::*;
#(
  parameter int LOAD_MINUTES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clear,
  input  logic       i_load,
  input  logic       i_tick,
  output bcd_digit_t o_minutes,
  output sec_tens_t  o_sec_tens,
  output bcd_digit_t o_sec_units,
  output logic       o_zero
);

  bcd_digit_t r_minutes;
  sec_tens_t  r_sec_tens;
  bcd_digit_t r_sec_units;
  logic       w_zero;

  assign w_zero = (r_minutes == 4'd0) && (r_sec_tens == 3'd0) && (r_sec_units == 4'd0);

  // Clear, load RUN:00 or decrement one second with borrow chain units->tens->minutes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_minutes   <= 4'd0;
      r_sec_tens  <= 3'd0;
      r_sec_units <= 4'd0;
    end else if (i_clear) begin
      r_minutes   <= 4'd0;
      r_sec_tens  <= 3'd0;
      r_sec_units <= 4'd0;
    end else if (i_load) begin
      r_minutes   <= 4'(LOAD_MINUTES);
      r_sec_tens  <= 3'd0;
      r_sec_units <= 4'd0;
    end else if (i_tick && !w_zero) begin
      if (r_sec_units != 4'd0) begin
        r_sec_units <= r_sec_units - 4'd1;
      end else begin
        r_sec_units <= MAX_BCD;
        if (r_sec_tens != 3'd0) begin
          r_sec_tens <= r_sec_tens - 3'd1;
        end else begin
          r_sec_tens <= MAX_SEC_TENS;
          r_minutes  <= r_minutes - 4'd1;
        end
      end
    end
  end

  assign o_minutes   = r_minutes;
  assign o_sec_tens  = r_sec_tens;
  assign o_sec_units = r_sec_units;
  assign o_zero      = w_zero;

endmodule

// File: rtl/multi_zone_irrigation_sequencer.sv
// Round-robin multi-zone irrigation controller with gauge checking,
// refill hysteresis and an M:SS run timer.
module multi_zone_irrigation_sequencer
  import irrigation_pkg::*;
#(
  parameter int ZONES       = 4,
  parameter int LEVELS      = 3,
  parameter int RUN_MINUTES = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              tick,
  input  logic [LEVELS-1:0] water_level,
  input  logic [ZONES-1:0]  earth_dry,
  input  logic              air_humidity,
  input  logic              low_temperature,
  output logic [ZONES-1:0]  zone_active,
  output logic              sprinkler_on,
  output logic              dripper_on,
  output logic              supply_valve,
  output logic              alarm,
  output logic              sensor_error,
  output logic [3:0]        timer_minutes,
  output logic [2:0]        timer_sec_tens,
  output logic [3:0]        timer_sec_units,
  output state_t            dbg_state
);

  localparam int ZW = $clog2(ZONES);

  state_t            r_state;
  mode_t             r_mode;
  logic [ZW-1:0]     r_ptr;
  logic [ZW-1:0]     r_zone;
  logic [ZONES-1:0]  r_zone_active;
  logic              r_sprinkler;
  logic              r_dripper;
  logic              r_sensor_error;
  logic              r_alarm;
  logic              r_supply;

  logic [7:0]        w_gauge8;
  logic              w_gauge_valid;
  logic              w_found;
  logic [ZW-1:0]     w_pick;
  logic [ZW-1:0]     w_ptr_next;
  logic [ZONES-1:0]  w_onehot;
  mode_t             w_mode_pick;
  logic              w_exit_stop;
  logic              w_exit_done;
  logic              w_load;
  logic              w_clear;
  logic              w_dec;
  logic              w_zero;

  // Zero-extend the gauge so the shared validity check works for any LEVELS.
  always_comb begin
    w_gauge8 = '0;
    w_gauge8[LEVELS-1:0] = water_level;
  end

  assign w_gauge_valid = gauge_is_thermometer(w_gauge8);

  // First dry zone at or after the pointer; scanning from the far end lets the nearest win.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = ZONES - 1; k >= 0; k--) begin
      if (earth_dry[(int'(r_ptr) + k) % ZONES]) begin
        w_found = 1'b1;
        w_pick  = ZW'((int'(r_ptr) + k) % ZONES);
      end
    end
  end

  assign w_ptr_next  = (r_zone == ZW'(ZONES - 1)) ? '0 : r_zone + ZW'(1);
  assign w_onehot    = {{(ZONES-1){1'b0}}, 1'b1} << r_zone;
  assign w_mode_pick = (!air_humidity && !low_temperature && water_level[1]) ? SPRINKLE : DRIP;

  // Early stop (zone wet or reservoir empty) needs no tick; completion needs a tick at 0:00.
  assign w_exit_stop = !earth_dry[r_zone] || !water_level[0];
  assign w_exit_done = tick && w_zero;

  // Timer control: load on the run decision, clear whenever a gauge fault is
  // pending or being served, count down only while the run continues.
  assign w_load  = (r_state == IDLE) && !r_sensor_error && water_level[0] && w_found;
  assign w_clear = (r_state == FAULT) || r_sensor_error;
  assign w_dec   = (r_state == IRRIGATE) && !r_sensor_error && tick && !w_exit_stop;

  bcd_countdown #(
    .LOAD_MINUTES(RUN_MINUTES)
  ) u_timer (
    .clk        (clock),
    .rst_n      (reset_n),
    .i_clear    (w_clear),
    .i_load     (w_load),
    .i_tick     (w_dec),
    .o_minutes  (timer_minutes),
    .o_sec_tens (timer_sec_tens),
    .o_sec_units(timer_sec_units),
    .o_zero     (w_zero)
  );

  // Sequencer FSM; zone/pump outputs are registered from the current state so they trail it by one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_mode        <= DRIP;
      r_ptr         <= '0;
      r_zone        <= '0;
      r_zone_active <= '0;
      r_sprinkler   <= 1'b0;
      r_dripper     <= 1'b0;
    end else begin
      r_zone_active <= (r_state == IRRIGATE) ? w_onehot : '0;
      r_sprinkler   <= (r_state == IRRIGATE) && (r_mode == SPRINKLE);
      r_dripper     <= (r_state == IRRIGATE) && (r_mode == DRIP);
      case (r_state)
        IDLE: begin
          if (r_sensor_error) begin
            r_state <= FAULT;
          end else if (water_level[0] && w_found) begin
            r_zone  <= w_pick;
            r_mode  <= w_mode_pick;
            r_state <= IRRIGATE;
          end
        end
        IRRIGATE: begin
          if (r_sensor_error) begin
            r_state <= FAULT;
          end else if (w_exit_done || w_exit_stop) begin
            r_state <= IDLE;
            r_ptr   <= w_ptr_next;
          end
        end
        FAULT: begin
          if (tick && w_gauge_valid) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gauge conflict and alarm flags, registered from the raw gauge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sensor_error <= 1'b0;
      r_alarm        <= 1'b0;
    end else begin
      r_sensor_error <= !w_gauge_valid;
      r_alarm        <= !w_gauge_valid || !water_level[1];
    end
  end

  // Refill valve: open when the bottom sensor is dry, close at the top sensor, hold between.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_supply <= 1'b0;
    end else if (r_sensor_error || (r_state == FAULT)) begin
      r_supply <= 1'b0;
    end else if (!water_level[0]) begin
      r_supply <= 1'b1;
    end else if (water_level[LEVELS-1]) begin
      r_supply <= 1'b0;
    end
  end

  assign zone_active  = r_zone_active;
  assign sprinkler_on = r_sprinkler;
  assign dripper_on   = r_dripper;
  assign supply_valve = r_supply;
  assign alarm        = r_alarm;
  assign sensor_error = r_sensor_error;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_multi_zone_irrigation_sequencer.sv
// Directed bench for the irrigation sequencer: a RUN_MINUTES=1 instance for
// the main scenarios and a RUN_MINUTES=2 instance for the mid-run reset case.
module tb_multi_zone_irrigation_sequencer;
  import irrigation_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset_n;
  logic       reset_n2;
  logic       tick;
  logic [2:0] water_level;
  logic [3:0] earth_dry;
  logic       air_humidity;
  logic       low_temperature;

  always #5 clock = ~clock;

  logic [3:0] zone_active;
  logic       sprinkler_on, dripper_on, supply_valve, alarm, sensor_error;
  logic [3:0] timer_minutes, timer_sec_units;
  logic [2:0] timer_sec_tens;
  state_t     dbg_state;

  logic [3:0] z2_zone_active;
  logic       z2_sprinkler_on, z2_dripper_on, z2_supply_valve, z2_alarm, z2_sensor_error;
  logic [3:0] z2_timer_minutes, z2_timer_sec_units;
  logic [2:0] z2_timer_sec_tens;
  state_t     z2_dbg_state;

  multi_zone_irrigation_sequencer #(.ZONES(4), .LEVELS(3), .RUN_MINUTES(1)) u_dut (
    .clock(clock), .reset_n(reset_n), .tick(tick), .water_level(water_level),
    .earth_dry(earth_dry), .air_humidity(air_humidity), .low_temperature(low_temperature),
    .zone_active(zone_active), .sprinkler_on(sprinkler_on), .dripper_on(dripper_on),
    .supply_valve(supply_valve), .alarm(alarm), .sensor_error(sensor_error),
    .timer_minutes(timer_minutes), .timer_sec_tens(timer_sec_tens),
    .timer_sec_units(timer_sec_units), .dbg_state(dbg_state)
  );

  multi_zone_irrigation_sequencer #(.ZONES(4), .LEVELS(3), .RUN_MINUTES(2)) u_dut2 (
    .clock(clock), .reset_n(reset_n2), .tick(tick), .water_level(water_level),
    .earth_dry(earth_dry), .air_humidity(air_humidity), .low_temperature(low_temperature),
    .zone_active(z2_zone_active), .sprinkler_on(z2_sprinkler_on), .dripper_on(z2_dripper_on),
    .supply_valve(z2_supply_valve), .alarm(z2_alarm), .sensor_error(z2_sensor_error),
    .timer_minutes(z2_timer_minutes), .timer_sec_tens(z2_timer_sec_tens),
    .timer_sec_units(z2_timer_sec_units), .dbg_state(z2_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Packs an expected M:SS display the same way the observed one is packed.
  function automatic logic [31:0] tv(input int m, input int t, input int u);
    logic [10:0] p;
    p = {4'(m), 3'(t), 4'(u)};
    return 32'(p);
  endfunction

  function automatic logic [31:0] t1();
    logic [10:0] p;
    p = {timer_minutes, timer_sec_tens, timer_sec_units};
    return 32'(p);
  endfunction

  function automatic logic [31:0] t2();
    logic [10:0] p;
    p = {z2_timer_minutes, z2_timer_sec_tens, z2_timer_sec_units};
    return 32'(p);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_tick(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(posedge clock);
      #1;
      tick = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n         = 1'b0;
    reset_n2        = 1'b0;
    tick            = 1'b0;
    water_level     = 3'b011;
    earth_dry       = 4'b0000;
    air_humidity    = 1'b0;
    low_temperature = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Reset state
    check("rst_zone",   32'(zone_active), 32'h0);
    check("rst_spr",    32'(sprinkler_on), 32'h0);
    check("rst_drip",   32'(dripper_on), 32'h0);
    check("rst_supply", 32'(supply_valve), 32'h0);
    check("rst_alarm",  32'(alarm), 32'h0);
    check("rst_serr",   32'(sensor_error), 32'h0);
    check("rst_timer",  t1(), tv(0, 0, 0));
    check("rst_state",  32'(dbg_state), 32'(IDLE));

    // Round robin: 1010 from pointer 0 -> zone 1, sprinkle
    earth_dry = 4'b1010;
    cyc();
    check("dec_state",  32'(dbg_state), 32'(IRRIGATE));
    check("dec_timer",  t1(), tv(1, 0, 0));
    check("dec_zone_lag", 32'(zone_active), 32'h0);
    cyc();
    check("run1_zone",  32'(zone_active), 32'b0010);
    check("run1_spr",   32'(sprinkler_on), 32'h1);
    check("run1_drip",  32'(dripper_on), 32'h0);
    check("run1_alarm", 32'(alarm), 32'h0);
    pulse_tick(30);
    check("run1_t030",  t1(), tv(0, 3, 0));
    pulse_tick(30);
    check("run1_t000",  t1(), tv(0, 0, 0));
    check("run1_hold",  32'(zone_active), 32'b0010);
    pulse_tick(1);
    check("run1_exit",  32'(dbg_state), 32'(IDLE));
    cyc();
    check("gap_zone",   32'(zone_active), 32'h0);
    cyc();
    check("run2_zone",  32'(zone_active), 32'b1000);
    check("run2_timer", t1(), tv(1, 0, 0));
    pulse_tick(61);
    cyc();
    cyc();
    check("run3_zone",  32'(zone_active), 32'b0010);

    // Early stop at 0:37; 0101 distinguishes pointer 2 (zone 2) from pointer 0
    pulse_tick(23);
    check("es_t037",    t1(), tv(0, 3, 7));
    earth_dry = 4'b0101;
    cyc();
    check("es_state",   32'(dbg_state), 32'(IDLE));
    check("es_hold",    t1(), tv(0, 3, 7));
    cyc();
    check("es_zone0",   32'(zone_active), 32'h0);
    check("es_spr0",    32'(sprinkler_on), 32'h0);
    cyc();
    check("es_next",    32'(zone_active), 32'b0100);

    // Gauge conflict during a run
    water_level = 3'b101;
    cyc();
    cyc();
    cyc();
    check("flt_serr",   32'(sensor_error), 32'h1);
    check("flt_alarm",  32'(alarm), 32'h1);
    check("flt_state",  32'(dbg_state), 32'(FAULT));
    check("flt_zone",   32'(zone_active), 32'h0);
    check("flt_spr",    32'(sprinkler_on), 32'h0);
    check("flt_drip",   32'(dripper_on), 32'h0);
    check("flt_supply", 32'(supply_valve), 32'h0);
    check("flt_timer",  t1(), tv(0, 0, 0));
    water_level = 3'b001;
    earth_dry   = 4'b0000;
    cyc();
    check("flt_wait",   32'(dbg_state), 32'(FAULT));
    pulse_tick(1);
    check("flt_exit",   32'(dbg_state), 32'(IDLE));
    check("flt_serr0",  32'(sensor_error), 32'h0);

    // Refill hysteresis
    water_level = 3'b000;
    cyc();
    check("hy_000",     32'(supply_valve), 32'h1);
    check("hy_alarm",   32'(alarm), 32'h1);
    water_level = 3'b001;
    cyc();
    check("hy_001",     32'(supply_valve), 32'h1);
    water_level = 3'b011;
    cyc();
    check("hy_011",     32'(supply_valve), 32'h1);
    water_level = 3'b111;
    cyc();
    check("hy_111",     32'(supply_valve), 32'h0);
    check("hy_alarm0",  32'(alarm), 32'h0);
    water_level = 3'b011;
    cyc();
    check("hy_011b",    32'(supply_valve), 32'h0);

    // Humid start -> drip, latched through a humidity change
    air_humidity = 1'b1;
    earth_dry    = 4'b0001;
    cyc();
    cyc();
    check("dr_zone",    32'(zone_active), 32'b0001);
    check("dr_drip",    32'(dripper_on), 32'h1);
    check("dr_spr",     32'(sprinkler_on), 32'h0);
    air_humidity = 1'b0;
    cyc();
    cyc();
    check("dr_latch",   32'(dripper_on), 32'h1);
    check("dr_spr2",    32'(sprinkler_on), 32'h0);
    earth_dry = 4'b0000;
    cyc();

    // Mid-run asynchronous reset on the RUN_MINUTES=2 instance
    reset_n2  = 1'b1;
    earth_dry = 4'b0010;
    cyc();
    cyc();
    check("r2_zone1",   32'(z2_zone_active), 32'b0010);
    earth_dry = 4'b0000;
    cyc();
    earth_dry = 4'b1111;
    cyc();
    cyc();
    check("r2_zone2",   32'(z2_zone_active), 32'b0100);
    pulse_tick(48);
    check("r2_t112",    t2(), tv(1, 1, 2));
    check("r2_spr",     32'(z2_sprinkler_on), 32'h1);
    reset_n2 = 1'b0;
    #1;
    check("ar_zone",    32'(z2_zone_active), 32'h0);
    check("ar_spr",     32'(z2_sprinkler_on), 32'h0);
    check("ar_timer",   t2(), tv(0, 0, 0));
    check("ar_state",   32'(z2_dbg_state), 32'(IDLE));
    @(posedge clock);
    #1;
    reset_n2 = 1'b1;
    cyc();
    cyc();
    check("ar_ptr0",    32'(z2_zone_active), 32'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
